// File: rtl/sha256_mb_core.sv
// Multi-block SHA-256/SHA-224 compression engine: takes pre-padded 512-bit blocks,
// chains the hash state across the blocks of a message, runs 1, 2 or 4 rounds per
// clock and builds the message schedule in a 16-word sliding window.
module sha256_mb_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit SUPPORT_224      = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         blk_mode224,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] digest,
    output logic         dig_is224,
    output logic         busy
);
    localparam int         R      = ROUNDS_PER_CYCLE;
    localparam logic [5:0] T_STEP = 6'(R);
    localparam logic [5:0] T_LAST = 6'(64 - R);

    generate
        if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
            $error("sha256_mb_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [255:0] IV_256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV_224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_w [16];
    logic [31:0]    r_v [8];
    logic [31:0]    r_h [8];
    logic [5:0]     r_t;
    logic           r_last;
    logic           r_mode;
    logic [255:0]   r_digest;
    logic           r_dig_valid;
    logic           r_dig_is224;

    logic [31:0]    w_w_nxt [16];
    logic [31:0]    w_v_nxt [8];
    logic [31:0]    w_hsum [8];
    logic [255:0]   w_hsum_flat;
    logic [255:0]   w_iv_sel;
    logic [31:0]    w_t1;
    logic [31:0]    w_t2;
    logic [31:0]    w_wnew;
    logic [5:0]     w_kidx;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign w_iv_sel  = (SUPPORT_224 && blk_mode224) ? IV_224 : IV_256;
    assign blk_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign dig_valid = r_dig_valid;
    assign digest    = r_digest;
    assign dig_is224 = r_dig_is224;

    // R chained rounds per cycle; each round consumes window word 0 and appends W[t+16]
    always_comb begin
        w_v_nxt = r_v;
        w_w_nxt = r_w;
        w_t1    = '0;
        w_t2    = '0;
        w_wnew  = '0;
        w_kidx  = '0;
        for (int j = 0; j < R; j++) begin
            w_kidx = r_t + 6'(j);
            w_t1   = w_v_nxt[7] + bsig1(w_v_nxt[4])
                   + ((w_v_nxt[4] & w_v_nxt[5]) ^ (~w_v_nxt[4] & w_v_nxt[6]))
                   + K_TAB[w_kidx] + w_w_nxt[0];
            w_t2   = bsig0(w_v_nxt[0])
                   + ((w_v_nxt[0] & w_v_nxt[1]) ^ (w_v_nxt[0] & w_v_nxt[2]) ^ (w_v_nxt[1] & w_v_nxt[2]));
            w_wnew = ssig1(w_w_nxt[14]) + w_w_nxt[9] + ssig0(w_w_nxt[1]) + w_w_nxt[0];
            w_v_nxt[7] = w_v_nxt[6];
            w_v_nxt[6] = w_v_nxt[5];
            w_v_nxt[5] = w_v_nxt[4];
            w_v_nxt[4] = w_v_nxt[3] + w_t1;
            w_v_nxt[3] = w_v_nxt[2];
            w_v_nxt[2] = w_v_nxt[1];
            w_v_nxt[1] = w_v_nxt[0];
            w_v_nxt[0] = w_t1 + w_t2;
            for (int k = 0; k < 15; k++) begin
                w_w_nxt[k] = w_w_nxt[k + 1];
            end
            w_w_nxt[15] = w_wnew;
        end
    end

    // Feed-forward sum of the chaining value and the working variables
    always_comb begin
        w_hsum_flat = '0;
        for (int i = 0; i < 8; i++) begin
            w_hsum[i] = r_h[i] + r_v[i];
            w_hsum_flat[255 - 32*i -: 32] = w_hsum[i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (blk_valid) w_state_nxt = S_ROUND;
            S_ROUND: if (r_t == T_LAST) w_state_nxt = S_FINAL;
            S_FINAL: w_state_nxt = r_last ? S_OUT : S_IDLE;
            S_OUT:   if (dig_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working variables and schedule window: loaded on acceptance, advanced every round cycle
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && blk_valid) begin
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= blk_data[511 - 32*i -: 32];
            end
            for (int i = 0; i < 8; i++) begin
                r_v[i] <= blk_first ? w_iv_sel[255 - 32*i -: 32] : r_h[i];
            end
        end else if (r_state == S_ROUND) begin
            r_v <= w_v_nxt;
            r_w <= w_w_nxt;
        end
    end

    // Chaining state, round counter, message flags and the digest output register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_h[i] <= IV_256[255 - 32*i -: 32];
            end
            r_t         <= '0;
            r_last      <= 1'b0;
            r_mode      <= 1'b0;
            r_digest    <= '0;
            r_dig_valid <= 1'b0;
            r_dig_is224 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (blk_valid) begin
                        r_t    <= '0;
                        r_last <= blk_last;
                        if (blk_first) begin
                            r_mode <= SUPPORT_224 && blk_mode224;
                            for (int i = 0; i < 8; i++) begin
                                r_h[i] <= w_iv_sel[255 - 32*i -: 32];
                            end
                        end
                    end
                end
                S_ROUND: r_t <= r_t + T_STEP;
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        r_h[i] <= w_hsum[i];
                    end
                    if (r_last) begin
                        r_dig_valid <= 1'b1;
                        r_dig_is224 <= r_mode;
                        r_digest    <= r_mode ? {w_hsum_flat[255:32], 32'h0} : w_hsum_flat;
                    end
                end
                S_OUT: if (dig_ready) r_dig_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_mb_core.sv
// Bench for sha256_mb_core: four instances (R=1, R=2, R=4, and R=4 SHA-256-only)
// checked against known digests and a plain array-based SHA-256 reference model.
module tb_sha256_mb_core;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h18};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_BLK1  =
        512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] TWO_BLK2  = {448'h0, 64'h1c0};
    localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] TWO256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] EMPTY256 = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic rst;
    logic t_vld [4], t_first [4], t_last [4], t_m224 [4], t_drdy [4];
    logic [511:0] t_data [4];
    logic o_rdy [4], o_dvld [4], o_is224 [4], o_busy [4];
    logic [255:0] o_dig [4];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [255:0] mh [4];
    logic         mm [4];
    logic [255:0] exp_d [4];
    logic         exp_224 [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            sha256_mb_core #(
                .ROUNDS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4)),
                .SUPPORT_224(g == 3 ? 1'b0 : 1'b1)
            ) u_dut (
                .clk(clk), .reset(rst),
                .blk_valid(t_vld[g]), .blk_ready(o_rdy[g]), .blk_data(t_data[g]),
                .blk_first(t_first[g]), .blk_last(t_last[g]), .blk_mode224(t_m224[g]),
                .dig_valid(o_dvld[g]), .dig_ready(t_drdy[g]), .digest(o_dig[g]),
                .dig_is224(o_is224[g]), .busy(o_busy[g])
            );
        end
    endgenerate

    function automatic int rlat(input int idx);
        return (idx == 0) ? 65 : (idx == 1) ? 33 : 17;
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straightforward FIPS 180-4 compression with the full 64-word schedule
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int k = 7; k > 0; k--) v[k] = v[k-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return hout;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mh[i] = IV256;
            mm[i] = 1'b0;
        end
    endtask

    // Offer a block (called at a negedge), return the cycle stamp of the acceptance edge
    task automatic send_block(input int idx, input logic [511:0] d, input logic f, input logic l,
                              input logic m, output int acc);
        int n = 0;
        t_data[idx] = d; t_first[idx] = f; t_last[idx] = l; t_m224[idx] = m; t_vld[idx] = 1'b1;
        while (o_rdy[idx] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        acc = cyc;
        t_vld[idx] = 1'b0; t_data[idx] = rand512();
        t_first[idx] = 1'($urandom); t_last[idx] = 1'($urandom); t_m224[idx] = 1'($urandom);
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL accept_timeout inst %0d ready %b required 1", idx, o_rdy[idx]);
        end
        if (f) begin
            mm[idx] = (idx != 3) ? m : 1'b0;
            mh[idx] = mm[idx] ? IV224 : IV256;
        end
        mh[idx] = compress(mh[idx], d);
        if (l) begin
            exp_d[idx]   = mm[idx] ? {mh[idx][255:32], 32'h0} : mh[idx];
            exp_224[idx] = mm[idx];
        end
    endtask

    task automatic wait_digest(input int idx, input int acc, input logic [255:0] ed, input logic e224,
                               input string nm);
        int n = 0;
        bit quiet = 1'b1;
        while (o_dvld[idx] !== 1'b1 && n < 300) begin
            if (o_rdy[idx] !== 1'b0 || o_busy[idx] !== 1'b1) quiet = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin errors++; $display("FAIL %s_timeout inst %0d dig_valid %b required 1", nm, idx, o_dvld[idx]); end
        checks++;
        if (cyc - acc !== rlat(idx)) begin errors++; $display("FAIL %s_latency inst %0d got %0d required %0d", nm, idx, cyc - acc, rlat(idx)); end
        checks++;
        if (o_dig[idx] !== ed) begin errors++; $display("FAIL %s_digest inst %0d got %h required %h", nm, idx, o_dig[idx], ed); end
        checks++;
        if (o_is224[idx] !== e224) begin errors++; $display("FAIL %s_is224 inst %0d got %b required %b", nm, idx, o_is224[idx], e224); end
        checks++;
        if (!quiet) begin errors++; $display("FAIL %s_busy inst %0d ready/busy got changed required 0/1 while hashing", nm, idx); end
    endtask

    task automatic wait_idle(input int idx, input int acc, input string nm);
        int n = 0;
        bit quiet = 1'b1;
        while (o_rdy[idx] !== 1'b1 && n < 300) begin
            if (o_dvld[idx] !== 1'b0) quiet = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc - acc !== rlat(idx)) begin errors++; $display("FAIL %s_ready_return inst %0d got %0d required %0d", nm, idx, cyc - acc, rlat(idx)); end
        checks++;
        if (!quiet) begin errors++; $display("FAIL %s_no_digest inst %0d dig_valid got 1 required 0", nm, idx); end
    endtask

    task automatic pop_digest(input int idx, input bit keep);
        t_drdy[idx] = 1'b1;
        @(negedge clk);
        if (!keep) t_drdy[idx] = 1'b0;
        checks++;
        if (o_dvld[idx] !== 1'b0) begin errors++; $display("FAIL pop_dig_valid inst %0d got %b required 0", idx, o_dvld[idx]); end
        checks++;
        if (o_rdy[idx] !== 1'b1) begin errors++; $display("FAIL pop_ready inst %0d got %b required 1", idx, o_rdy[idx]); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            checks += 5;
            if (o_rdy[i] !== 1'b1) begin errors++; $display("FAIL reset_ready inst %0d got %b required 1", i, o_rdy[i]); end
            if (o_busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d got %b required 0", i, o_busy[i]); end
            if (o_dvld[i] !== 1'b0) begin errors++; $display("FAIL reset_dig_valid inst %0d got %b required 0", i, o_dvld[i]); end
            if (o_dig[i] !== 256'h0) begin errors++; $display("FAIL reset_digest inst %0d got %h required 0", i, o_dig[i]); end
            if (o_is224[i] !== 1'b0) begin errors++; $display("FAIL reset_is224 inst %0d got %b required 0", i, o_is224[i]); end
        end
    endtask

    task automatic test_first_without_first();
        int acc;
        send_block(2, ABC_BLK, 1'b0, 1'b1, 1'b1, acc);
        wait_digest(2, acc, ABC256, 1'b0, "nofirst");
        pop_digest(2, 1'b0);
    endtask

    task automatic test_abc();
        int acc;
        send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b0, acc);
        wait_digest(0, acc, ABC256, 1'b0, "abc");
        pop_digest(0, 1'b0);
    endtask

    task automatic test_abc224();
        int acc;
        send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b1, acc);
        wait_digest(0, acc, ABC224, 1'b1, "abc224");
        pop_digest(0, 1'b0);
        send_block(3, ABC_BLK, 1'b1, 1'b1, 1'b1, acc);
        wait_digest(3, acc, ABC256, 1'b0, "no224");
        pop_digest(3, 1'b0);
    endtask

    task automatic test_two_block();
        int acc1, acc2;
        send_block(0, TWO_BLK1, 1'b1, 1'b0, 1'b0, acc1);
        wait_idle(0, acc1, "two_blk1");
        send_block(0, TWO_BLK2, 1'b0, 1'b1, 1'b1, acc2);
        checks++;
        if (acc2 - acc1 !== 66) begin errors++; $display("FAIL two_blk_throughput got %0d required 66", acc2 - acc1); end
        wait_digest(0, acc2, TWO256, 1'b0, "two_blk2");
        pop_digest(0, 1'b0);
    endtask

    task automatic test_empty_fast();
        int acc;
        for (int i = 1; i <= 2; i++) begin
            send_block(i, EMPTY_BLK, 1'b1, 1'b1, 1'b0, acc);
            wait_digest(i, acc, EMPTY256, 1'b0, "empty");
            pop_digest(i, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int acc, hcyc;
        send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b0, acc);
        wait_digest(0, acc, ABC256, 1'b0, "bp");
        t_data[0] = EMPTY_BLK; t_first[0] = 1'b1; t_last[0] = 1'b1; t_m224[0] = 1'b0; t_vld[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 3;
            if (o_dvld[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b required 1", i, o_dvld[0]); end
            if (o_dig[0] !== ABC256) begin errors++; $display("FAIL bp_hold_digest cycle %0d got %h required %h", i, o_dig[0], ABC256); end
            if (o_rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b required 0", i, o_rdy[0]); end
        end
        t_drdy[0] = 1'b1;
        @(negedge clk);
        hcyc = cyc;
        t_drdy[0] = 1'b0;
        checks += 2;
        if (o_dvld[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b required 0", o_dvld[0]); end
        if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b required 1", o_rdy[0]); end
        @(negedge clk);
        acc = cyc;
        t_vld[0] = 1'b0;
        checks += 2;
        if (acc !== hcyc + 1) begin errors++; $display("FAIL bp_accept_cycle got %0d required %0d", acc, hcyc + 1); end
        if (o_busy[0] !== 1'b1) begin errors++; $display("FAIL bp_accept_busy got %b required 1", o_busy[0]); end
        wait_digest(0, acc, EMPTY256, 1'b0, "bp_next");
        pop_digest(0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int acc;
        send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b0, acc);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks += 3;
        if (o_busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b required 0", o_busy[0]); end
        if (o_dvld[0] !== 1'b0) begin errors++; $display("FAIL midreset_dig_valid got %b required 0", o_dvld[0]); end
        if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b required 1", o_rdy[0]); end
        send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b0, acc);
        wait_digest(0, acc, ABC256, 1'b0, "midreset_abc");
        pop_digest(0, 1'b0);
    endtask

    // Random multi-block messages with dig_ready held high throughout
    task automatic test_random();
        int acc, nb;
        logic f;
        for (int idx = 0; idx < 4; idx++) begin
            t_drdy[idx] = 1'b1;
            for (int m = 0; m < 5; m++) begin
                nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) begin
                    f = (b == 0) && (m == 0 || $urandom_range(0, 3) != 0);
                    send_block(idx, rand512(), f, (b == nb - 1), 1'($urandom), acc);
                    if (b == nb - 1) begin
                        wait_digest(idx, acc, exp_d[idx], exp_224[idx], "rand");
                        pop_digest(idx, 1'b1);
                    end else begin
                        wait_idle(idx, acc, "rand_mid");
                    end
                end
            end
            t_drdy[idx] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            t_vld[i] = 1'b0; t_first[i] = 1'b0; t_last[i] = 1'b0; t_m224[i] = 1'b0;
            t_drdy[i] = 1'b0; t_data[i] = '0;
        end
        rst = 1'b1;
        test_reset();
        test_first_without_first();
        test_abc();
        test_abc224();
        test_two_block();
        test_empty_fast();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, checks %0d", checks);
        $fatal(1);
    end
endmodule
